// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath width and opcode constants
package alu_pkg;

    // Datapath width, shared with the ALU control decoder
    localparam int ALU_WIDTH = 32;

    // ALUCon operation encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // True when the op needs the adder in subtract mode (SUB, and SLT's a-b)
    function automatic logic op_is_sub(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared adder/subtractor with carry-out and signed overflow
//   a, b  : operands
//   sub   : 1 computes a - b, 0 computes a + b
//   sum   : result modulo 2^WIDTH
//   cout  : carry out of the MSB (for subtract: 1 means no borrow)
//   ovf   : two's-complement signed overflow
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    // Subtract as a + ~b + 1 so one carry chain serves both directions
    assign b_eff    = sub ? ~b : b;
    assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    assign sum  = full_sum[WIDTH-1:0];
    assign cout = full_sum[WIDTH];

    // Overflow when both addends share a sign and the sum's sign differs
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered MIPS-style integer ALU for the execute stage
//   clk, rst : rising-edge clock, synchronous active-high reset
//   ALUCon   : operation select (alu_pkg opcodes)
//   a, b     : operands
//   out      : registered result, valid one clock after inputs are sampled
//   zero     : registered flag, 1 when out == 0 (branch-equal via SUB)
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ALUCon,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    logic             addsub_sub;
    logic [WIDTH-1:0] addsub_sum;
    logic             addsub_cout_unused;
    logic             addsub_ovf;
    logic             slt_bit;
    logic [WIDTH-1:0] r;

    assign addsub_sub = op_is_sub(ALUCon);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (addsub_sub),
        .sum  (addsub_sum),
        .cout (addsub_cout_unused),
        .ovf  (addsub_ovf)
    );

    // Sign of a-b is wrong exactly when the subtraction overflowed
    assign slt_bit = addsub_sum[WIDTH-1] ^ addsub_ovf;

    always_comb begin
        r = '0;
        case (ALUCon)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = addsub_sum;
            ALU_SUB: r = addsub_sum;
            ALU_SLT: r = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_NOR: r = ~(a | b);
            default: r = '0;
        endcase
    end

    // out and zero update on the same edge so they are never skewed
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            zero <= 1'b1;
        end else begin
            out  <= r;
            zero <= (r == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized self-checking bench for alu
module tb_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  ALUCon;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;

    int n_cmp;
    int n_fail;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .ALUCon (ALUCon),
        .a      (a),
        .b      (b),
        .out    (out),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ALU semantics written directly as arithmetic on integers
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
            4'b0110: return 32'((64'h1_0000_0000 + 64'(x) - 64'(y)) % 64'h1_0000_0000);
            4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    // Present one op; return after the capturing edge plus settling time
    task automatic step(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        ALUCon = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(4'b0010, 32'd5, 32'd7);
            n_cmp++;
            if (out !== 32'd0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: out=%h zero=%b, expected out=00000000 zero=1", i, out, zero);
            end
        end
        rst = 1'b0;
        step(4'b0010, 32'd5, 32'd7);
        n_cmp++;
        if (out !== 32'd12 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: out=%h zero=%b, expected out=0000000c zero=0", out, zero);
        end
    endtask

    task automatic test_directed;
        logic [3:0]  t_op  [12];
        logic [31:0] t_a   [12];
        logic [31:0] t_b   [12];
        logic [31:0] t_out [12];
        t_op[0]  = 4'b0010; t_a[0]  = 32'd4;          t_b[0]  = 32'd4;          t_out[0]  = 32'd8;
        t_op[1]  = 4'b0110; t_a[1]  = 32'd4;          t_b[1]  = 32'd4;          t_out[1]  = 32'd0;
        t_op[2]  = 4'b0110; t_a[2]  = 32'd0;          t_b[2]  = 32'd1;          t_out[2]  = 32'hFFFF_FFFF;
        t_op[3]  = 4'b0001; t_a[3]  = 32'd4;          t_b[3]  = 32'd4;          t_out[3]  = 32'd4;
        t_op[4]  = 4'b0000; t_a[4]  = 32'd4;          t_b[4]  = 32'd4;          t_out[4]  = 32'd4;
        t_op[5]  = 4'b0000; t_a[5]  = 32'd4;          t_b[5]  = 32'd2;          t_out[5]  = 32'd0;
        t_op[6]  = 4'b1100; t_a[6]  = 32'd0;          t_b[6]  = 32'd0;          t_out[6]  = 32'hFFFF_FFFF;
        t_op[7]  = 4'b0111; t_a[7]  = 32'd4;          t_b[7]  = 32'd2;          t_out[7]  = 32'd0;
        t_op[8]  = 4'b0111; t_a[8]  = 32'd4;          t_b[8]  = 32'd6;          t_out[8]  = 32'd1;
        t_op[9]  = 4'b0111; t_a[9]  = 32'hFFFF_FFFF;  t_b[9]  = 32'd1;          t_out[9]  = 32'd1;
        t_op[10] = 4'b0111; t_a[10] = 32'h8000_0000;  t_b[10] = 32'd1;          t_out[10] = 32'd1;
        t_op[11] = 4'b0111; t_a[11] = 32'h7FFF_FFFF;  t_b[11] = 32'h8000_0000;  t_out[11] = 32'd0;
        for (int i = 0; i < 12; i++) begin
            step(t_op[i], t_a[i], t_b[i]);
            n_cmp++;
            if (out !== t_out[i] || zero !== (t_out[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL directed%0d op=%b a=%h b=%h: out=%h zero=%b, expected out=%h zero=%b",
                         i, t_op[i], t_a[i], t_b[i], out, zero, t_out[i], t_out[i] == 32'd0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  t_op  [3];
        logic [31:0] t_a   [3];
        logic [31:0] t_b   [3];
        logic [31:0] t_out [3];
        logic        t_z   [3];
        t_op[0] = 4'b0010; t_a[0] = 32'd1; t_b[0] = 32'd2; t_out[0] = 32'd3; t_z[0] = 1'b0;
        t_op[1] = 4'b0110; t_a[1] = 32'd9; t_b[1] = 32'd9; t_out[1] = 32'd0; t_z[1] = 1'b1;
        t_op[2] = 4'b0001; t_a[2] = 32'd3; t_b[2] = 32'd4; t_out[2] = 32'd7; t_z[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(t_op[i], t_a[i], t_b[i]);
            n_cmp++;
            if (out !== t_out[i] || zero !== t_z[i]) begin
                n_fail++;
                $display("FAIL back_to_back%0d: out=%h zero=%b, expected out=%h zero=%b",
                         i, out, zero, t_out[i], t_z[i]);
            end
        end
    endtask

    task automatic test_illegal_and_wrap;
        logic [3:0] ill [2];
        ill[0] = 4'b0011;
        ill[1] = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step(4'b0001, 32'd1, 32'd0);
            step(ill[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            n_cmp++;
            if (out !== 32'd0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_op_%b: out=%h zero=%b, expected out=00000000 zero=1", ill[i], out, zero);
            end
        end
        step(4'b0010, 32'hFFFF_FFFF, 32'd1);
        n_cmp++;
        if (out !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL add_wrap: out=%h zero=%b, expected out=00000000 zero=1", out, zero);
        end
    endtask

    task automatic test_mid_reset;
        step(4'b0010, 32'd100, 32'd23);
        rst = 1'b1;
        step(4'b0010, 32'd40, 32'd2);
        n_cmp++;
        if (out !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_discard: out=%h zero=%b, expected out=00000000 zero=1", out, zero);
        end
        rst = 1'b0;
        step(4'b0001, 32'h0000_00F0, 32'h0000_000F);
        n_cmp++;
        if (out !== 32'h0000_00FF || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_first: out=%h zero=%b, expected out=000000ff zero=0", out, zero);
        end
    endtask

    task automatic test_random;
        logic [3:0]  ops [8];
        logic [31:0] edge_vals [6];
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp_out;
        logic        do_rst;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'($urandom); ops[7] = 4'b0111;
        edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF; edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF; edge_vals[4] = 32'h0000_0001; edge_vals[5] = 32'h8000_0001;
        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == ops[6]) op = 4'($urandom);
            x  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
            y  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 9) == 0) y = x;
            do_rst = ($urandom_range(0, 19) == 0);
            rst = do_rst;
            exp_out = do_rst ? 32'd0 : model(op, x, y);
            step(op, x, y);
            n_cmp++;
            if (out !== exp_out || zero !== (exp_out == 32'd0)) begin
                n_fail++;
                $display("FAIL random%0d op=%b a=%h b=%h rst=%b: out=%h zero=%b, expected out=%h zero=%b",
                         i, op, x, y, do_rst, out, zero, exp_out, exp_out == 32'd0);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        ALUCon = 4'b0000;
        a      = 32'd0;
        b      = 32'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal_and_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
